// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator I/O path: default widths and the
// RLE result-transmitter state set, so encoder and decompressor agree on the format.
package accel_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_RUN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SCAN,
        ST_EMIT,
        ST_FLUSH,
        ST_DONE
    } rle_state_t;

    // Largest run count that fits in one tx byte/nibble.
    function automatic int runMax(input int runW);
        return (1 << runW) - 1;
    endfunction

endpackage

// File: rtl/rle_tx_out_reg.sv
// Holding register for one run count on the valid/ack channel. A load may carry a
// pending-zero request, which sends an extra empty run right after the loaded one.
module rle_tx_out_reg #(
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [RUN_W-1:0] i_loadData,
    input  logic             i_loadZero,
    input  logic             i_ack,
    output logic [RUN_W-1:0] o_txData,
    output logic             o_txValid,
    output logic             o_emitDone
);

    logic [RUN_W-1:0] r_data;
    logic             r_valid;
    logic             r_pendZero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_pendZero <= 1'b0;
        end else if (i_load) begin
            r_data     <= i_loadData;
            r_valid    <= 1'b1;
            r_pendZero <= i_loadZero;
        end else if (r_valid && i_ack) begin
            if (r_pendZero) begin
                r_data     <= '0;
                r_pendZero <= 1'b0;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // The whole emission (including any inserted zero) finishes on this accept.
    assign o_emitDone = r_valid && i_ack && !r_pendZero;
    assign o_txData   = r_data;
    assign o_txValid  = r_valid;

endmodule

// File: rtl/rle_result_tx.sv
// Reads a binary result image from RAM, run-length encodes it LSB-first starting
// with a zero run, and sends the run counts to the host over a valid/ack channel.
module rle_result_tx
    import accel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [RUN_W-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ack,
    output logic              interrupt,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(runMax(RUN_W));

    rle_state_t        r_state;
    logic [ADDR_W-1:0] r_baseAddr;
    logic [ADDR_W-1:0] r_numWords;
    logic [ADDR_W-1:0] r_wordIdx;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bitIdx;
    logic              r_curBit;
    logic [RUN_W-1:0]  r_run;
    logic              r_wordEnd;
    logic              r_memRdEn;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_interrupt;
    logic              r_busy;
    logic              r_done;

    logic              w_bit;
    logic              w_lastBit;
    logic              w_moreWords;
    logic              w_flip;
    logic              w_sat;
    logic [ADDR_W-1:0] w_nextAddr;
    logic              w_emitDone;
    logic              w_load;
    logic [RUN_W-1:0]  w_loadData;
    logic              w_loadZero;

    assign w_bit       = r_shift[0];
    assign w_lastBit   = (r_bitIdx == BIT_W'(DATA_W - 1));
    assign w_moreWords = ((r_wordIdx + ADDR_W'(1)) != r_numWords);
    assign w_flip      = (w_bit != r_curBit);
    assign w_sat       = !w_flip && (r_run == RUN_MAX);
    assign w_nextAddr  = r_baseAddr + r_wordIdx + ADDR_W'(1);

    // Loads go straight into the output register so EMIT/FLUSH show tx_valid on entry.
    always_comb begin
        w_load     = 1'b0;
        w_loadData = r_run;
        w_loadZero = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (w_flip || w_sat) begin
                    w_load     = 1'b1;
                    w_loadZero = w_sat;
                end else if (w_lastBit && !w_moreWords) begin
                    w_load     = 1'b1;
                    w_loadData = r_run + RUN_W'(1);
                end
            end
            ST_EMIT: begin
                if (w_emitDone && r_wordEnd && !w_moreWords) begin
                    w_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    rle_tx_out_reg #(.RUN_W(RUN_W)) u_outReg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_loadData (w_loadData),
        .i_loadZero (w_loadZero),
        .i_ack      (tx_ack),
        .o_txData   (tx_data),
        .o_txValid  (tx_valid),
        .o_emitDone (w_emitDone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_baseAddr  <= '0;
            r_numWords  <= '0;
            r_wordIdx   <= '0;
            r_shift     <= '0;
            r_bitIdx    <= '0;
            r_curBit    <= 1'b0;
            r_run       <= '0;
            r_wordEnd   <= 1'b0;
            r_memRdEn   <= 1'b0;
            r_memAddr   <= '0;
            r_interrupt <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_baseAddr  <= base_addr;
                            r_numWords  <= num_words;
                            r_wordIdx   <= '0;
                            r_curBit    <= 1'b0;
                            r_run       <= '0;
                            r_interrupt <= 1'b1;
                            r_memRdEn   <= 1'b1;
                            r_memAddr   <= base_addr;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_memRdEn <= 1'b0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_shift  <= mem_rdata;
                    r_bitIdx <= '0;
                    r_state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    r_shift  <= r_shift >> 1;
                    r_bitIdx <= r_bitIdx + BIT_W'(1);
                    // A saturated run keeps cur_bit: the zero inserted after it is the opposite run.
                    if (w_flip || w_sat) begin
                        r_run     <= RUN_W'(1);
                        r_curBit  <= r_curBit ^ w_flip;
                        r_wordEnd <= w_lastBit;
                        r_state   <= ST_EMIT;
                    end else begin
                        r_run <= r_run + RUN_W'(1);
                        if (w_lastBit) begin
                            if (w_moreWords) begin
                                r_wordIdx <= r_wordIdx + ADDR_W'(1);
                                r_memAddr <= w_nextAddr;
                                r_memRdEn <= 1'b1;
                                r_state   <= ST_FETCH;
                            end else begin
                                r_state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_emitDone) begin
                        if (!r_wordEnd) begin
                            r_state <= ST_SCAN;
                        end else if (w_moreWords) begin
                            r_wordIdx <= r_wordIdx + ADDR_W'(1);
                            r_memAddr <= w_nextAddr;
                            r_memRdEn <= 1'b1;
                            r_state   <= ST_FETCH;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_emitDone) begin
                        r_done      <= 1'b1;
                        r_interrupt <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_rd_en = r_memRdEn;
    assign mem_addr  = r_memAddr;
    assign interrupt = r_interrupt;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_rle_result_tx.sv
// Self-checking bench for rle_result_tx: an 8-bit-run and a 4-bit-run instance, with
// run lists predicted from the raw bitstream by a queue-based reference model.
module tb_rle_result_tx;

    logic        clk = 1'b0;
    logic        rst, start, start4, ack, ack4;
    logic [15:0] baseAddr, numWords;

    logic        memRdEn8, txValid8, interrupt8, busy8, done8;
    logic [15:0] memAddr8, rdata8;
    logic [7:0]  txData8;
    logic        memRdEn4, txValid4, interrupt4, busy4, done4;
    logic [15:0] memAddr4, rdata4;
    logic [3:0]  txData4;

    logic [15:0] mem [256];
    logic [15:0] words[$];
    int          expQ[$];
    int          got8[$], got4[$];
    int          vectors = 0, miscompares = 0;
    int          rdCount, busyCycles, doneCount, validSeen, intSeen, done4Count;
    logic        prevInt, intAtDone, intBeforeDone;
    int          ackMode = 0;
    bit          ack4Rand = 0;

    always #5 clk = ~clk;

    rle_result_tx #(.DATA_W(16), .ADDR_W(16), .RUN_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .base_addr(baseAddr), .num_words(numWords),
        .mem_rd_en(memRdEn8), .mem_addr(memAddr8), .mem_rdata(rdata8),
        .tx_data(txData8), .tx_valid(txValid8), .tx_ack(ack),
        .interrupt(interrupt8), .busy(busy8), .done(done8)
    );

    rle_result_tx #(.DATA_W(16), .ADDR_W(16), .RUN_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .base_addr(baseAddr), .num_words(numWords),
        .mem_rd_en(memRdEn4), .mem_addr(memAddr4), .mem_rdata(rdata4),
        .tx_data(txData4), .tx_valid(txValid4), .tx_ack(ack4),
        .interrupt(interrupt4), .busy(busy4), .done(done4)
    );

    // RAM model with one cycle of read latency.
    always @(posedge clk) begin
        rdata8 <= mem[memAddr8[7:0]];
        rdata4 <= mem[memAddr4[7:0]];
    end

    // Drive acks on the falling edge, then observe the settled DUT state.
    always @(negedge clk) begin
        if (ackMode == 1) ack = 1'($urandom_range(0, 1));
        else if (ackMode == 0) ack = 1'b1;
        ack4 = ack4Rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!rst) begin
            if (txValid8 && ack) got8.push_back(int'(txData8));
            if (memRdEn8) rdCount++;
            if (busy8) busyCycles++;
            if (interrupt8) intSeen++;
            if (txValid8) validSeen++;
            if (done8) begin
                doneCount++;
                intAtDone     = interrupt8;
                intBeforeDone = prevInt;
            end
            prevInt = interrupt8;
            if (txValid4 && ack4) got4.push_back(int'(txData4));
            if (done4) done4Count++;
        end
    end

    // Reference: split the bitstream into alternating maximal runs (zeros first),
    // then break any run longer than maxRun into maxRun, 0, maxRun, 0, ..., rest.
    function automatic void buildExp(input int maxRun);
        int bits[$];
        int cur, i, len, rem;
        expQ.delete();
        foreach (words[w]) for (int b = 0; b < 16; b++) bits.push_back(int'(words[w][b]));
        cur = 0;
        i   = 0;
        while (i < bits.size()) begin
            len = 0;
            while (i < bits.size() && bits[i] == cur) begin
                len++;
                i++;
            end
            rem = len;
            while (rem > maxRun) begin
                expQ.push_back(maxRun);
                expQ.push_back(0);
                rem -= maxRun;
            end
            expQ.push_back(rem);
            cur = 1 - cur;
        end
    endfunction

    function automatic bit sameQ(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string qStr(input int q[$]);
        string s = "";
        for (int i = 0; i < q.size() && i < 30; i++) s = {s, $sformatf("%0d ", q[i])};
        if (q.size() > 30) s = {s, "..."};
        return s;
    endfunction

    task automatic clearMon();
        got8.delete();
        got4.delete();
        rdCount = 0; busyCycles = 0; doneCount = 0; validSeen = 0; intSeen = 0; done4Count = 0;
        prevInt = 1'b0; intAtDone = 1'b1; intBeforeDone = 1'b0;
    endtask

    task automatic startXfer(input int base, input int nw, input bit use4);
        clearMon();
        foreach (words[i]) mem[(base + i) % 256] = words[i];
        @(negedge clk);
        baseAddr = 16'(base);
        numWords = 16'(nw);
        if (use4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic waitDone(input bit use4);
        int cyc = 0;
        while (((use4 ? done4Count : doneCount) == 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({memRdEn8, memAddr8, txData8, txValid8, interrupt8, busy8, done8} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset8: got %h expected 0",
                     {memRdEn8, memAddr8, txData8, txValid8, interrupt8, busy8, done8});
        end
        vectors++;
        if ({memRdEn4, memAddr4, txData4, txValid4, interrupt4, busy4, done4} !== 25'd0) begin
            miscompares++;
            $display("[TB] FAIL reset4: got %h expected 0",
                     {memRdEn4, memAddr4, txData4, txValid4, interrupt4, busy4, done4});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int base, expBusy;
        ackMode = 0;
        for (int k = 0; k < 5; k++) begin
            words.delete();
            case (k)
                0: words.push_back(16'h0000);
                1: words.push_back(16'hFFFF);
                2: words.push_back(16'h00F0);
                3: begin words.push_back(16'h8000); words.push_back(16'h0001); end
                default: for (int i = 0; i < 17; i++) words.push_back(16'h0000);
            endcase
            base = int'($urandom_range(0, 200));
            startXfer(base, words.size(), 1'b0);
            waitDone(1'b0);
            buildExp(255);
            expBusy = words.size() * 18 + expQ.size() + 1;
            vectors++;
            if (!sameQ(got8, expQ)) begin
                miscompares++;
                $display("[TB] FAIL directed%0d runs: got [%s] expected [%s]", k, qStr(got8), qStr(expQ));
            end
            vectors++;
            if (busyCycles != expBusy) begin
                miscompares++;
                $display("[TB] FAIL directed%0d cycles: got %0d expected %0d", k, busyCycles, expBusy);
            end
            vectors++;
            if (doneCount != 1 || intAtDone !== 1'b0 || intBeforeDone !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL directed%0d done/irq: got done=%0d irq@done=%b irq_before=%b expected 1 0 1",
                         k, doneCount, intAtDone, intBeforeDone);
            end
            vectors++;
            if (rdCount != words.size()) begin
                miscompares++;
                $display("[TB] FAIL directed%0d reads: got %0d expected %0d", k, rdCount, words.size());
            end
        end
    endtask

    task automatic test_run_w4();
        int nw;
        for (int k = 0; k < 9; k++) begin
            words.delete();
            if (k == 0) begin
                ack4Rand = 1'b0;
                words.push_back(16'h0000);
            end else begin
                ack4Rand = 1'b1;
                nw = int'($urandom_range(1, 3));
                for (int i = 0; i < nw; i++)
                    words.push_back(($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom));
            end
            startXfer(int'($urandom_range(0, 200)), words.size(), 1'b1);
            waitDone(1'b1);
            buildExp(15);
            vectors++;
            if (!sameQ(got4, expQ) || done4Count != 1) begin
                miscompares++;
                $display("[TB] FAIL runw4_%0d: got [%s] done=%0d expected [%s] done=1",
                         k, qStr(got4), done4Count, qStr(expQ));
            end
        end
        ack4Rand = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int cyc;
        words.delete();
        words.push_back(16'h00F0);
        buildExp(255);
        ackMode = 2;
        ack = 1'b0;
        startXfer(17, 1, 1'b0);
        cyc = 0;
        while (!txValid8 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        held = txData8;
        vectors++;
        if (!txValid8 || int'(held) != expQ[0]) begin
            miscompares++;
            $display("[TB] FAIL bp_first: got valid=%b data=%0d expected valid=1 data=%0d", txValid8, held, expQ[0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (!txValid8 || txData8 !== held) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, txValid8, txData8, held);
            end
        end
        ackMode = 1;
        waitDone(1'b0);
        vectors++;
        if (!sameQ(got8, expQ)) begin
            miscompares++;
            $display("[TB] FAIL bp_runs: got [%s] expected [%s]", qStr(got8), qStr(expQ));
        end
        ackMode = 0;
    endtask

    task automatic test_start_busy();
        words.delete();
        words.push_back(16'($urandom));
        words.push_back(16'h0F0F);
        buildExp(255);
        startXfer(40, 2, 1'b0);
        repeat (6) @(negedge clk);
        baseAddr = 16'd90;
        numWords = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(1'b0);
        vectors++;
        if (!sameQ(got8, expQ) || rdCount != 2 || doneCount != 1) begin
            miscompares++;
            $display("[TB] FAIL start_busy: got [%s] reads=%0d done=%0d expected [%s] reads=2 done=1",
                     qStr(got8), rdCount, doneCount, qStr(expQ));
        end
    endtask

    task automatic test_zero_words();
        words.delete();
        startXfer(5, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (doneCount != 1) begin
            miscompares++;
            $display("[TB] FAIL zero_done: got %0d pulses expected 1", doneCount);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (rdCount != 0 || validSeen != 0 || intSeen != 0 || doneCount != 1) begin
            miscompares++;
            $display("[TB] FAIL zero_quiet: got reads=%0d valid=%0d irq=%0d done=%0d expected 0 0 0 1",
                     rdCount, validSeen, intSeen, doneCount);
        end
    endtask

    task automatic test_reset_mid_emit();
        int cyc;
        words.delete();
        words.push_back(16'hFFFF);
        ackMode = 2;
        ack = 1'b0;
        startXfer(60, 1, 1'b0);
        cyc = 0;
        while (!txValid8 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (!txValid8) begin
            miscompares++;
            $display("[TB] FAIL rst_emit_wait: got valid=0 expected 1");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({memRdEn8, memAddr8, txData8, txValid8, interrupt8, busy8, done8} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_emit_outs: got %h expected 0",
                     {memRdEn8, memAddr8, txData8, txValid8, interrupt8, busy8, done8});
        end
        @(negedge clk);
        rst = 1'b0;
        ackMode = 0;
        repeat (40) @(negedge clk);
        vectors++;
        if (doneCount != 0 || got8.size() != 0 || txValid8 !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_emit_after: got done=%0d tx=%0d valid=%b busy=%b expected 0 0 0 0",
                     doneCount, got8.size(), txValid8, busy8);
        end
    endtask

    task automatic test_random();
        int nw, sel;
        ackMode = 1;
        for (int k = 0; k < 20; k++) begin
            words.delete();
            nw = int'($urandom_range(1, 4));
            for (int i = 0; i < nw; i++) begin
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0: words.push_back(16'h0000);
                    1: words.push_back(16'hFFFF);
                    default: words.push_back(16'($urandom));
                endcase
            end
            buildExp(255);
            startXfer(int'($urandom_range(0, 200)), nw, 1'b0);
            waitDone(1'b0);
            vectors++;
            if (!sameQ(got8, expQ) || rdCount != nw || doneCount != 1) begin
                miscompares++;
                $display("[TB] FAIL random%0d: got [%s] reads=%0d done=%0d expected [%s] reads=%0d done=1",
                         k, qStr(got8), rdCount, doneCount, qStr(expQ), nw);
            end
        end
        ackMode = 0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        start4   = 1'b0;
        ack      = 1'b1;
        ack4     = 1'b1;
        baseAddr = '0;
        numWords = '0;
        foreach (mem[i]) mem[i] = 16'h0000;
        clearMon();
        test_reset();
        test_directed();
        test_run_w4();
        test_backpressure();
        test_start_busy();
        test_zero_words();
        test_reset_mid_emit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rle_result_tx.md
Name: rle_result_tx

Overview:
- Output-side counterpart of the input path (I/O interface, decompressor, DMA write).
- Once the CNN finishes, it reads a binary result image from result RAM.
- It run-length encodes the image and transmits the run counts to the host over a valid/ack byte channel.
- `interrupt` is held high for the whole transfer and falls on completion.

Parameters:
- DATA_W, 16, RAM word width; bits are consumed LSB-first.
- ADDR_W, 16, RAM address width.
- RUN_W, 8, width of one run count on the tx channel; RUN_MAX = 2^RUN_W - 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a transfer when idle
- base_addr  in  ADDR_W  first RAM word address, sampled on accepted start
- num_words  in  ADDR_W  number of words to send, sampled on accepted start
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM data, valid exactly 1 cycle after mem_rd_en
- tx_data  out  RUN_W  run count
- tx_valid  out  1  tx_data valid
- tx_ack  in  1  host accepts; a transfer occurs on a cycle with tx_valid && tx_ack
- interrupt  out  1  high from accepted start until the final transfer completes
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset: all outputs 0; state IDLE; cur_bit=0; run=0; counters 0.
- Reset takes priority over everything, mid-transfer included; it aborts with no done pulse and no further tx.
- Encoding:
  - The bitstream is the words in address order, each word LSB-first.
  - Runs alternate, starting with zeros; a first run of 0 is emitted if bit 0 is 1.
  - Runs continue across word boundaries.
- Saturation: if a run reaches RUN_MAX and the next bit equals cur_bit:
  - emit RUN_MAX, then emit 0 (empty opposite run);
  - the bit is consumed and run restarts at 1.
- States:
  - IDLE: on start with num_words=0, go to DONE; no reads, no tx. On start with num_words>0, latch inputs, interrupt=1, go to FETCH. start while busy is ignored.
  - FETCH: mem_rd_en=1, mem_addr=base+word_idx, for one cycle; go to WAIT.
  - WAIT: capture mem_rdata into the shift register; bit_idx=0; go to SCAN.
  - SCAN: one bit per cycle.
    - bit==cur_bit and run<RUN_MAX: run++.
    - bit!=cur_bit: load run into tx_data; flip cur_bit; run=1; go to EMIT.
    - Saturation case: go to EMIT with the pending-zero flag set.
    - After bit DATA_W-1: if more words remain, go to FETCH; otherwise go to FLUSH. This applies once any pending EMIT has completed.
  - EMIT: tx_valid=1; tx_data is stable until ack. On ack, if the pending-zero flag is set, emit 0 next (flag clears); otherwise resume at the next bit, next word, or FLUSH.
  - FLUSH: emit the final run, which is always ≥1, via the same valid/ack rule; on ack go to DONE.
  - DONE: done=1 and interrupt=0 for one cycle; go to IDLE.
- tx_ack while tx_valid=0 is ignored.
- tx_valid never drops without an ack, except on rst.
- Throughput with tx_ack tied high: FETCH+WAIT (2 cycles) per word, 1 cycle per bit, plus 1 cycle per emitted run.

Decomposition:
- Shared package (accel_pkg):
  - state enum for IDLE/FETCH/WAIT/SCAN/EMIT/FLUSH/DONE;
  - RUN_MAX derivation;
  - default widths (DATA_W, ADDR_W, RUN_W), also used by the decompressor so both ends agree on the RLE format.
- One natural sub-module: rle_tx_out_reg, the tx_data/tx_valid holding register with ack handshake and pending-zero insertion.

Test Plan:
- num_words=1, word 16'h0000, ack tied high → tx 16; done pulse; interrupt falls the same cycle as done.
- word 16'hFFFF → tx 0, 16.
- word 16'h00F0 → tx 4, 4, 8.
- Two words 16'h8000, 16'h0001 → tx 15, 2, 15; this checks a run spanning a word boundary.
- RUN_W=4, word 16'h0000 → tx 15, 0, 1.
- Backpressure: hold tx_ack low 5 cycles with tx_valid high → tx_data unchanged and no run lost.
- Edge cases:
  - start during busy → ignored;
  - num_words=0 → done within 2 cycles, no tx_valid, no mem_rd_en;
  - rst mid-EMIT → outputs 0 next cycle, no done.
